// File: rtl/fp_pkg.sv
// Shared float helpers and sequencing states for the FC output stages.
// Functions use the package default widths; parameterized blocks derive their own.
package fp_pkg;

  localparam int EXPONENT_WIDTH = 8;
  localparam int MANTISSA_WIDTH = 23;
  localparam int DATA_WIDTH     = EXPONENT_WIDTH + MANTISSA_WIDTH + 1;

  localparam logic [DATA_WIDTH-1:0] FP_POS_ZERO = {DATA_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic is_nan(input logic [DATA_WIDTH-1:0] x);
    return (&x[DATA_WIDTH-2:MANTISSA_WIDTH]) && (|x[MANTISSA_WIDTH-1:0]);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] fp_relu(input logic [DATA_WIDTH-1:0] x);
    if (x[DATA_WIDTH-1] || is_nan(x)) begin
      return FP_POS_ZERO;
    end else begin
      return x;
    end
  endfunction

endpackage

// File: rtl/fp_relu.sv
// Combinational float ReLU: negatives (incl. -0, -inf) and NaN collapse to +0.
// The nan flag lets the caller record that a NaN was squashed.
module fp_relu
  import fp_pkg::*;
#(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23,
  parameter int DATA_WIDTH     = EXPONENT_WIDTH + MANTISSA_WIDTH + 1
) (
  input  logic [DATA_WIDTH-1:0] value,
  output logic [DATA_WIDTH-1:0] rectified,
  output logic                  nan
);

  // Rectify one word and flag NaN inputs.
  always_comb begin
    nan = (&value[DATA_WIDTH-2:MANTISSA_WIDTH]) && (|value[MANTISSA_WIDTH-1:0]);
    if (value[DATA_WIDTH-1] || nan) begin
      rectified = {DATA_WIDTH{1'b0}};
    end else begin
      rectified = value;
    end
  end

endmodule

// File: rtl/fc_argmax_relu.sv
// FC output stage: rectifies each neuron output, forwards it, and reports the
// arg-max (lowest index on ties) and a NaN flag once per complete frame.
module fc_argmax_relu
  import fp_pkg::*;
#(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23,
  parameter int DATA_WIDTH     = EXPONENT_WIDTH + MANTISSA_WIDTH + 1,
  parameter int NUM_CLASSES    = 10,
  parameter int IDX_WIDTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  relu_valid,
  output logic [DATA_WIDTH-1:0] relu_data,
  output logic                  class_valid,
  output logic [IDX_WIDTH-1:0]  class_idx,
  output logic [DATA_WIDTH-1:0] class_max,
  output logic                  nan_seen,
  output logic                  busy
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

  state_t                state_r, state_next_s;
  logic [IDX_WIDTH-1:0]  count_r, idx_r, idx_next_s;
  logic [DATA_WIDTH-1:0] max_r, max_next_s, rect_s;
  logic                  nan_r, nan_next_s, nan_s;
  logic                  accept_s, greater_s, last_s;

  fp_relu #(
    .EXPONENT_WIDTH (EXPONENT_WIDTH),
    .MANTISSA_WIDTH (MANTISSA_WIDTH),
    .DATA_WIDTH     (DATA_WIDTH)
  ) u_relu (
    .value     (in_data),
    .rectified (rect_s),
    .nan       (nan_s)
  );

  // Handshake and status depend only on the state register.
  assign in_ready    = (state_r == ACCUM);
  assign busy        = (state_r == ACCUM);
  assign class_valid = (state_r == DONE);

  // Running max update; rectified words are non-negative so magnitude bits order them.
  always_comb begin
    accept_s   = in_valid && (state_r == ACCUM);
    greater_s  = (rect_s[DATA_WIDTH-2:0] > max_r[DATA_WIDTH-2:0]);
    last_s     = (count_r == LAST_IDX);
    max_next_s = max_r;
    idx_next_s = idx_r;
    if (greater_s) begin
      max_next_s = rect_s;
      idx_next_s = count_r;
    end else begin
      max_next_s = max_r;
      idx_next_s = idx_r;
    end
    nan_next_s = nan_r | nan_s;
  end

  // Next-state logic; start always (re)opens a frame.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = start ? ACCUM : IDLE;
      ACCUM: begin
        if (start) begin
          state_next_s = ACCUM;
        end else if (accept_s && last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = ACCUM;
        end
      end
      DONE:    state_next_s = start ? ACCUM : IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State, frame accumulators and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      count_r    <= {IDX_WIDTH{1'b0}};
      idx_r      <= {IDX_WIDTH{1'b0}};
      max_r      <= {DATA_WIDTH{1'b0}};
      nan_r      <= 1'b0;
      relu_valid <= 1'b0;
      relu_data  <= {DATA_WIDTH{1'b0}};
      class_idx  <= {IDX_WIDTH{1'b0}};
      class_max  <= {DATA_WIDTH{1'b0}};
      nan_seen   <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      relu_valid <= accept_s;
      if (accept_s) begin
        relu_data <= rect_s;
      end else begin
        relu_data <= relu_data;
      end
      if (start) begin
        count_r <= {IDX_WIDTH{1'b0}};
        idx_r   <= {IDX_WIDTH{1'b0}};
        max_r   <= {DATA_WIDTH{1'b0}};
        nan_r   <= 1'b0;
      end else if (accept_s) begin
        max_r   <= max_next_s;
        idx_r   <= idx_next_s;
        nan_r   <= nan_next_s;
        count_r <= last_s ? {IDX_WIDTH{1'b0}} : count_r + {{(IDX_WIDTH-1){1'b0}}, 1'b1};
        if (last_s) begin
          class_idx <= idx_next_s;
          class_max <= max_next_s;
          nan_seen  <= nan_next_s;
        end else begin
          class_idx <= class_idx;
        end
      end else begin
        count_r <= count_r;
      end
    end
  end

endmodule
